// File: rtl/vec_pkg.sv
// Shared encodings and instruction field layout for the vector issue sequencer.
package vec_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_e;

  localparam int INSTR_W = 32;
  localparam int REG_W   = 5;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RS_HI = 26;
  localparam int RS_LO = 22;
  localparam int RT_HI = 21;
  localparam int RT_LO = 17;
  localparam int RD_HI = 16;
  localparam int RD_LO = 12;

  localparam int MAX_VL_DEF    = 8;
  localparam int VL_W_DEF      = 4;
  localparam int BCAST_BIT_DEF = 11;

  // Register numbers wrap modulo 32, so r31 + 1 lands on r0.
  function automatic logic [REG_W-1:0] reg_add(input logic [REG_W-1:0] r,
                                               input logic [REG_W-1:0] off);
    logic [REG_W-1:0] sum;
    sum = r + off;
    return sum;
  endfunction

endpackage

// File: rtl/vec_field_rewrite.sv
// Offsets the rs/rt/rd fields of an instruction by an element index.
// Purely combinational so a future vector hazard unit can reuse it to
// predict the registers touched by upcoming micro-ops.
module vec_field_rewrite
  import vec_pkg::*;
#(
  parameter int VL_W = VL_W_DEF
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [VL_W-1:0]    elem,
  input  logic               bcast,
  output logic [INSTR_W-1:0] uop
);

  logic [REG_W-1:0] off;

  // Copy every field, then replace the three register specifiers.
  always_comb begin
    off = REG_W'(elem);
    uop = instr;
    uop[RS_HI:RS_LO] = bcast ? instr[RS_HI:RS_LO] : reg_add(instr[RS_HI:RS_LO], off);
    uop[RT_HI:RT_LO] = reg_add(instr[RT_HI:RT_LO], off);
    uop[RD_HI:RD_LO] = reg_add(instr[RD_HI:RD_LO], off);
  end

endmodule

// File: rtl/vec_issue_seq.sv
// Vector issue sequencer sitting between IF/ID and the ID-stage decode.
// Expands a vector instruction into vl scalar micro-ops, one per cycle.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | scalar pass-through; waiting for a vector instr with vl != 0
//   ISSUE | emitting micro-ops of the captured instr, uop_elem = element
module vec_issue_seq
  import vec_pkg::*;
#(
  parameter int MAX_VL    = MAX_VL_DEF,
  parameter int VL_W      = VL_W_DEF,
  parameter int BCAST_BIT = BCAST_BIT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic               id_is_vec,
  input  logic               hazard_stall,
  input  logic               flush,
  input  logic               vl_wr,
  input  logic [VL_W-1:0]    vl_wdata,
  output logic               seq_stall,
  output logic               uop_valid,
  output logic [INSTR_W-1:0] uop_instr,
  output logic [VL_W-1:0]    uop_elem,
  output logic               uop_last,
  output logic [VL_W-1:0]    vl,
  output logic               busy
);

  localparam logic [VL_W-1:0] MAX_VL_V = VL_W'(MAX_VL);
  localparam logic [VL_W-1:0] ONE_V    = VL_W'(1);

  seq_state_e         state_q;
  logic [INSTR_W-1:0] vinstr_q;
  logic [VL_W-1:0]    vlen_q;

  logic               idle;
  logic               start;
  logic [INSTR_W-1:0] rw_src;
  logic [VL_W-1:0]    rw_elem;
  logic [VL_W-1:0]    rw_len;
  logic               rw_last;
  logic [INSTR_W-1:0] rw_uop;

  // The rewriter always computes the *next* micro-op: element 0 of the
  // instruction in ID while idle, otherwise element+1 of the held copy.
  always_comb begin
    idle    = (state_q == IDLE);
    start   = idle && id_is_vec && (vl != '0) && !hazard_stall && !flush;
    rw_src  = idle ? id_instr : vinstr_q;
    rw_elem = idle ? '0 : (uop_elem + ONE_V);
    rw_len  = idle ? vl : vlen_q;
    rw_last = (rw_elem == (rw_len - ONE_V));
  end

  vec_field_rewrite #(
    .VL_W (VL_W)
  ) u_rewrite (
    .instr (rw_src),
    .elem  (rw_elem),
    .bcast (rw_src[BCAST_BIT]),
    .uop   (rw_uop)
  );

  // Fetch is held for the whole sequence except the last element, which
  // lets IF/ID advance on the same edge the sequencer drops back to idle.
  always_comb begin
    seq_stall = 1'b0;
    if (!reset && !flush) begin
      if (idle)
        seq_stall = id_is_vec && (vl != '0);
      else
        seq_stall = !(uop_last && !hazard_stall);
    end
  end

  assign busy = (state_q == ISSUE);

  // Sequencer FSM with registered micro-op outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      vinstr_q  <= '0;
      vlen_q    <= '0;
      uop_valid <= 1'b0;
      uop_instr <= '0;
      uop_elem  <= '0;
      uop_last  <= 1'b0;
    end else if (flush) begin
      state_q   <= IDLE;
      uop_valid <= 1'b0;
      uop_instr <= '0;
      uop_elem  <= '0;
      uop_last  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            // vl sampled here is the pre-write value if vl_wr hits this edge.
            vinstr_q  <= id_instr;
            vlen_q    <= vl;
            state_q   <= ISSUE;
            uop_valid <= 1'b1;
            uop_instr <= rw_uop;
            uop_elem  <= '0;
            uop_last  <= rw_last;
          end
        end
        ISSUE: begin
          if (!hazard_stall) begin
            if (uop_last) begin
              state_q   <= IDLE;
              uop_valid <= 1'b0;
              uop_instr <= '0;
              uop_elem  <= '0;
              uop_last  <= 1'b0;
            end else begin
              uop_instr <= rw_uop;
              uop_elem  <= rw_elem;
              uop_last  <= rw_last;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          uop_valid <= 1'b0;
        end
      endcase
    end
  end

  // Architectural VL register, saturated to MAX_VL on write.
  always_ff @(posedge clk) begin
    if (reset)
      vl <= MAX_VL_V;
    else if (vl_wr)
      vl <= (vl_wdata > MAX_VL_V) ? MAX_VL_V : vl_wdata;
  end

endmodule

// File: tb/tb_vec_issue_seq.sv
// Directed bench for vec_issue_seq. Inputs change 1 time unit after the
// rising edge, outputs are checked 1 unit later, well away from the edge.
module tb_vec_issue_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id_instr;
  logic        id_is_vec;
  logic        hazard_stall;
  logic        flush;
  logic        vl_wr;
  logic [3:0]  vl_wdata;
  logic        seq_stall;
  logic        uop_valid;
  logic [31:0] uop_instr;
  logic [3:0]  uop_elem;
  logic        uop_last;
  logic [3:0]  vl;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vec_issue_seq dut (
    .clk          (clk),
    .reset        (reset),
    .id_instr     (id_instr),
    .id_is_vec    (id_is_vec),
    .hazard_stall (hazard_stall),
    .flush        (flush),
    .vl_wr        (vl_wr),
    .vl_wdata     (vl_wdata),
    .seq_stall    (seq_stall),
    .uop_valid    (uop_valid),
    .uop_instr    (uop_instr),
    .uop_elem     (uop_elem),
    .uop_last     (uop_last),
    .vl           (vl),
    .busy         (busy)
  );

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic bc);
    return {op, rs, rt, rd, bc, 11'h2A5};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_vl(input logic [3:0] v);
    vl_wr    = 1'b1;
    vl_wdata = v;
    tick();
    vl_wr    = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    id_is_vec = 1'b1;
    id_instr  = mk(5'd1, 5'd1, 5'd1, 5'd1, 1'b0);
    tick();
    tick();
    #1;
    n_cmp++; if (seq_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0b want 0", seq_stall); end
    n_cmp++; if (vl !== 4'd8) begin n_err++; $display("FAIL reset_vl: got %0d want 8", vl); end
    n_cmp++; if (uop_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", uop_valid); end
    n_cmp++; if (uop_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %08h want 0", uop_instr); end
    n_cmp++; if (uop_elem !== 4'd0) begin n_err++; $display("FAIL reset_elem: got %0d want 0", uop_elem); end
    n_cmp++; if (uop_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %0b want 0", uop_last); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
    reset     = 1'b0;
    id_is_vec = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [4:0] rs_e [4] = '{5'd2, 5'd3, 5'd4, 5'd5};
    logic [4:0] rt_e [4] = '{5'd5, 5'd6, 5'd7, 5'd8};
    logic [4:0] rd_e [4] = '{5'd9, 5'd10, 5'd11, 5'd12};
    write_vl(4'd4);
    id_instr  = mk(5'd3, 5'd2, 5'd5, 5'd9, 1'b0);
    id_is_vec = 1'b1;
    #1;
    n_cmp++; if (seq_stall !== 1'b1) begin n_err++; $display("FAIL basic_stall_T: got %0b want 1", seq_stall); end
    n_cmp++; if (uop_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_T: got %0b want 0", uop_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      n_cmp++; if (uop_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid[%0d]: got %0b want 1", k, uop_valid); end
      n_cmp++; if (uop_elem !== 4'(k)) begin n_err++; $display("FAIL basic_elem[%0d]: got %0d want %0d", k, uop_elem, k); end
      n_cmp++; if (uop_instr !== mk(5'd3, rs_e[k], rt_e[k], rd_e[k], 1'b0)) begin n_err++; $display("FAIL basic_instr[%0d]: got %08h want %08h", k, uop_instr, mk(5'd3, rs_e[k], rt_e[k], rd_e[k], 1'b0)); end
      n_cmp++; if (uop_last !== (k == 3)) begin n_err++; $display("FAIL basic_last[%0d]: got %0b want %0b", k, uop_last, (k == 3)); end
      n_cmp++; if (seq_stall !== (k != 3)) begin n_err++; $display("FAIL basic_stall[%0d]: got %0b want %0b", k, seq_stall, (k != 3)); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy[%0d]: got %0b want 1", k, busy); end
    end
    tick();
    id_is_vec = 1'b0;
    id_instr  = mk(5'd6, 5'd1, 5'd2, 5'd3, 1'b0);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_done_busy: got %0b want 0", busy); end
    n_cmp++; if (uop_valid !== 1'b0) begin n_err++; $display("FAIL basic_done_valid: got %0b want 0", uop_valid); end
    n_cmp++; if (seq_stall !== 1'b0) begin n_err++; $display("FAIL basic_done_stall: got %0b want 0", seq_stall); end
  endtask

  task automatic test_bcast();
    logic [4:0] rt_e [3] = '{5'd30, 5'd31, 5'd0};
    logic [4:0] rd_e [3] = '{5'd31, 5'd0, 5'd1};
    write_vl(4'd3);
    id_instr  = mk(5'd7, 5'd7, 5'd30, 5'd31, 1'b1);
    id_is_vec = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      n_cmp++; if (uop_instr !== mk(5'd7, 5'd7, rt_e[k], rd_e[k], 1'b1)) begin n_err++; $display("FAIL bcast_instr[%0d]: got %08h want %08h", k, uop_instr, mk(5'd7, 5'd7, rt_e[k], rd_e[k], 1'b1)); end
      n_cmp++; if (uop_last !== (k == 2)) begin n_err++; $display("FAIL bcast_last[%0d]: got %0b want %0b", k, uop_last, (k == 2)); end
    end
    tick();
    id_is_vec = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bcast_done_busy: got %0b want 0", busy); end
  endtask

  task automatic test_hazard();
    logic       hz    [7] = '{0, 0, 1, 1, 0, 0, 0};
    logic       val   [7] = '{0, 1, 1, 1, 1, 1, 1};
    logic [3:0] el    [7] = '{0, 0, 1, 1, 1, 2, 3};
    logic       lst   [7] = '{0, 0, 0, 0, 0, 0, 1};
    logic       stl   [7] = '{1, 1, 1, 1, 1, 1, 0};
    int         stalls = 0;
    write_vl(4'd4);
    id_instr  = mk(5'd2, 5'd1, 5'd2, 5'd3, 1'b0);
    id_is_vec = 1'b1;
    for (int c = 0; c < 7; c++) begin
      hazard_stall = hz[c];
      #1;
      n_cmp++; if (uop_valid !== val[c]) begin n_err++; $display("FAIL hz_valid[%0d]: got %0b want %0b", c, uop_valid, val[c]); end
      n_cmp++; if (uop_elem !== el[c]) begin n_err++; $display("FAIL hz_elem[%0d]: got %0d want %0d", c, uop_elem, el[c]); end
      n_cmp++; if (uop_last !== lst[c]) begin n_err++; $display("FAIL hz_last[%0d]: got %0b want %0b", c, uop_last, lst[c]); end
      n_cmp++; if (seq_stall !== stl[c]) begin n_err++; $display("FAIL hz_stall[%0d]: got %0b want %0b", c, seq_stall, stl[c]); end
      if (c > 0) begin
        n_cmp++; if (uop_instr !== mk(5'd2, 5'd1 + 5'(el[c]), 5'd2 + 5'(el[c]), 5'd3 + 5'(el[c]), 1'b0)) begin n_err++; $display("FAIL hz_instr[%0d]: got %08h", c, uop_instr); end
      end
      if (seq_stall) stalls++;
      tick();
    end
    hazard_stall = 1'b0;
    id_is_vec    = 1'b0;
    #1;
    n_cmp++; if (stalls !== 6) begin n_err++; $display("FAIL hz_stall_total: got %0d want 6", stalls); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hz_done_busy: got %0b want 0", busy); end
  endtask

  task automatic test_hazard_idle();
    tick();
    id_instr     = mk(5'd4, 5'd8, 5'd8, 5'd8, 1'b0);
    id_is_vec    = 1'b1;
    hazard_stall = 1'b1;
    #1;
    n_cmp++; if (seq_stall !== 1'b1) begin n_err++; $display("FAIL hzi_stall: got %0b want 1", seq_stall); end
    tick();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hzi_no_capture: busy got %0b want 0", busy); end
    hazard_stall = 1'b0;
    tick();
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hzi_capture_busy: got %0b want 1", busy); end
    n_cmp++; if (uop_instr !== mk(5'd4, 5'd8, 5'd8, 5'd8, 1'b0)) begin n_err++; $display("FAIL hzi_capture_instr: got %08h", uop_instr); end
    flush = 1'b1;
    tick();
    flush     = 1'b0;
    id_is_vec = 1'b0;
    #1;
    n_cmp++; if (uop_valid !== 1'b0) begin n_err++; $display("FAIL hzi_flush_valid: got %0b want 0", uop_valid); end
  endtask

  task automatic test_flush();
    write_vl(4'd8);
    id_instr  = mk(5'd1, 5'd0, 5'd10, 5'd20, 1'b0);
    id_is_vec = 1'b1;
    #1;
    tick();
    tick();
    tick();
    flush = 1'b1;
    #1;
    n_cmp++; if (uop_elem !== 4'd2) begin n_err++; $display("FAIL flush_elem_before: got %0d want 2", uop_elem); end
    n_cmp++; if (seq_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall_cycle: got %0b want 0", seq_stall); end
    tick();
    flush     = 1'b0;
    id_is_vec = 1'b0;
    id_instr  = mk(5'd9, 5'd1, 5'd2, 5'd3, 1'b0);
    #1;
    n_cmp++; if (uop_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b want 0", uop_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %0b want 0", busy); end
    n_cmp++; if (seq_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall_after: got %0b want 0", seq_stall); end
    n_cmp++; if (uop_elem !== 4'd0) begin n_err++; $display("FAIL flush_elem_after: got %0d want 0", uop_elem); end
    tick();
    #1;
    n_cmp++; if (uop_valid !== 1'b0) begin n_err++; $display("FAIL flush_scalar_valid: got %0b want 0", uop_valid); end
  endtask

  task automatic test_vl_wr();
    write_vl(4'd15);
    #1;
    n_cmp++; if (vl !== 4'd8) begin n_err++; $display("FAIL vl_sat: got %0d want 8", vl); end
    write_vl(4'd0);
    #1;
    n_cmp++; if (vl !== 4'd0) begin n_err++; $display("FAIL vl_zero: got %0d want 0", vl); end
    id_instr  = mk(5'd5, 5'd1, 5'd1, 5'd1, 1'b0);
    id_is_vec = 1'b1;
    #1;
    n_cmp++; if (seq_stall !== 1'b0) begin n_err++; $display("FAIL vl0_stall: got %0b want 0", seq_stall); end
    tick();
    #1;
    n_cmp++; if (uop_valid !== 1'b0) begin n_err++; $display("FAIL vl0_valid: got %0b want 0", uop_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL vl0_busy: got %0b want 0", busy); end
    id_is_vec = 1'b0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (vl !== 4'd8) begin n_err++; $display("FAIL vl_after_reset: got %0d want 8", vl); end
  endtask

  task automatic test_vl_wr_mid();
    write_vl(4'd5);
    id_instr  = mk(5'd4, 5'd10, 5'd11, 5'd12, 1'b0);
    id_is_vec = 1'b1;
    #1;
    tick();
    for (int k = 0; k < 5; k++) begin
      vl_wr    = (k == 1);
      vl_wdata = 4'd2;
      #1;
      n_cmp++; if (uop_elem !== 4'(k)) begin n_err++; $display("FAIL mid_elem[%0d]: got %0d want %0d", k, uop_elem, k); end
      n_cmp++; if (uop_last !== (k == 4)) begin n_err++; $display("FAIL mid_last[%0d]: got %0b want %0b", k, uop_last, (k == 4)); end
      tick();
    end
    vl_wr     = 1'b0;
    id_is_vec = 1'b0;
    #1;
    n_cmp++; if (vl !== 4'd2) begin n_err++; $display("FAIL mid_vl: got %0d want 2", vl); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_done_busy: got %0b want 0", busy); end
    tick();
    id_instr  = mk(5'd4, 5'd0, 5'd0, 5'd0, 1'b0);
    id_is_vec = 1'b1;
    #1;
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if (uop_elem !== 4'(k)) begin n_err++; $display("FAIL mid2_elem[%0d]: got %0d want %0d", k, uop_elem, k); end
      n_cmp++; if (uop_last !== (k == 1)) begin n_err++; $display("FAIL mid2_last[%0d]: got %0b want %0b", k, uop_last, (k == 1)); end
      tick();
    end
    id_is_vec = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid2_done_busy: got %0b want 0", busy); end
  endtask

  task automatic test_same_edge();
    write_vl(4'd3);
    id_instr  = mk(5'd8, 5'd3, 5'd4, 5'd5, 1'b0);
    id_is_vec = 1'b1;
    vl_wr     = 1'b1;
    vl_wdata  = 4'd6;
    #1;
    tick();
    vl_wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (uop_last !== (k == 2)) begin n_err++; $display("FAIL same_last[%0d]: got %0b want %0b", k, uop_last, (k == 2)); end
      tick();
    end
    id_is_vec = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL same_done_busy: got %0b want 0", busy); end
    n_cmp++; if (vl !== 4'd6) begin n_err++; $display("FAIL same_vl: got %0d want 6", vl); end
  endtask

  initial begin
    reset        = 1'b1;
    id_instr     = 32'h0;
    id_is_vec    = 1'b0;
    hazard_stall = 1'b0;
    flush        = 1'b0;
    vl_wr        = 1'b0;
    vl_wdata     = 4'd0;
    test_reset();
    test_basic();
    test_bcast();
    test_hazard();
    test_hazard_idle();
    test_flush();
    test_vl_wr();
    test_vl_wr_mid();
    test_same_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vec_issue_seq.md
Name: vec_issue_seq

Overview:
- Vector issue sequencer between the IF/ID register and the ID-stage control/register-file read of the 5-stage pipeline.
- Scalar instructions pass untouched.
- A vector instruction in ID holds fetch (seq_stall) and is expanded into VL scalar micro-ops, one per cycle, with register fields offset by element index.
- Honours the load-use hazard stall and the branch flush.

Parameters:
- MAX_VL, 8, maximum vector length (elements).
- VL_W, 4, width of VL and element index; VL_W = clog2(MAX_VL+1).
- BCAST_BIT, 11, instruction bit (shamt field) that broadcasts rs as a scalar (rs not incremented).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- id_instr  in  32  instruction currently in ID (op[31:27], rs[26:22], rt[21:17], rd[16:12]).
- id_is_vec  in  1  decoder flag: id_instr is a vector instruction.
- hazard_stall  in  1  load-use stall from the hazard logic; freezes issue.
- flush  in  1  taken branch in MEM; aborts the sequence.
- vl_wr  in  1  write the VL register.
- vl_wdata  in  VL_W  new VL value.
- seq_stall  out  1  hold PC and IF/ID; bubble ID control (ORed into Stall).
- uop_valid  out  1  uop_instr replaces id_instr as ID-stage input this cycle.
- uop_instr  out  32  micro-op with rewritten rs/rt/rd.
- uop_elem  out  VL_W  element index of the current micro-op.
- uop_last  out  1  current micro-op is element VL-1.
- vl  out  VL_W  architectural VL register.
- busy  out  1  state is ISSUE.

Behaviour:
- Reset values: state IDLE, vl=MAX_VL, uop_valid=0, uop_instr=0, uop_elem=0, uop_last=0, busy=0. seq_stall is 0 while reset is high.
- States: IDLE, ISSUE.
- seq_stall is combinational: (IDLE & id_is_vec & vl!=0 & !flush) | (ISSUE & !(uop_last & !hazard_stall) & !flush).
- IDLE, scalar instruction: uop_valid=0; the pipeline uses id_instr.
- IDLE, id_is_vec & vl!=0 & !hazard_stall & !flush at edge:
  - capture id_instr and vl into vinstr and vlen;
  - go to ISSUE; elem=0.
- IDLE, id_is_vec & hazard_stall: remain in IDLE with seq_stall=1; capture on the first edge where hazard_stall=0.
- IDLE, vl==0: the vector instruction is a NOP. No stall, no micro-ops, no capture; uop_valid=0.
- ISSUE outputs (registered):
  - uop_valid=1, uop_elem=elem;
  - uop_instr = vinstr with rs'=rs+elem (or rs if vinstr[BCAST_BIT]=1), rt'=rt+elem, rd'=rd+elem;
  - all register fields are 5-bit modulo-32 (31+1 -> 0); other fields copied;
  - uop_last = (elem == vlen-1).
- Latency: vector instruction seen at cycle T (no hazard) -> element k valid in cycle T+1+k. Last element is at T+vlen, where seq_stall=0 so IF/ID advances at that edge. Return to IDLE after that edge. Total stall cycles = vlen.
- hazard_stall in ISSUE: hold elem, uop_instr, uop_valid and uop_last; no advance.
- flush (any state): next edge -> IDLE, uop_valid=0, elem=0. seq_stall=0 in the flush cycle. flush dominates hazard_stall and capture.
- vl_wr: vl <= min(vl_wdata, MAX_VL) at edge, in any state. An in-flight sequence uses the captured vlen. A vector instruction captured in the same edge as vl_wr uses the old vl.
- reset mid-ISSUE: abort; all outputs take reset values next cycle.
- id_is_vec while in ISSUE is ignored; the held instruction is the one being sequenced.

Decomposition:
- Package vec_pkg:
  - state encoding (IDLE=0, ISSUE=1);
  - field position constants (OP_HI=31, RS_LO=22, RT_LO=17, RD_LO=12, REG_W=5);
  - BCAST_BIT default.
- One sub-module vec_field_rewrite: combinational (instr, elem, bcast) -> rewritten instr. Reusable by a future vector hazard unit.

Test Plan:
- vl=4, vector instr rs=2 rt=5 rd=9 at T -> uops T+1..T+4 with (rs,rt,rd) = (2,5,9), (3,6,10), (4,7,11), (5,8,12); uop_last only at T+4; seq_stall=1 at T..T+3, 0 at T+4.
- vl=3, BCAST_BIT=1, rs=7 rt=30 rd=31 -> rs stays 7; rt 30,31,0; rd 31,0,1 (wrap).
- vl=4, hazard_stall high during element 1 for 2 cycles -> element 1 repeated 3 cycles, then elements 2 and 3 follow; total stall cycles = 6.
- flush during element 2 of vl=8 -> next cycle uop_valid=0, busy=0, seq_stall=0; a following scalar instruction passes with uop_valid=0.
- vl_wr with vl_wdata=15 -> vl reads 8; vl_wr vl_wdata=0, then vector instr -> no stall, no uops; reset -> vl=8.
- vl_wr vl_wdata=2 during a vl=5 sequence -> 5 uops issued; next vector instr issues 2.
